frame_pixel_streamer: RTL and testbench
=======================================

Name: frame_pixel_streamer

Overview:
- Upstream source for the RGB median-filter chain: reads RGB565 words from the frame-buffer read FIFO and emits an RGB888 per-pixel stream (tx_data_R/G/B, po_flag) with frame sync (o_vs).
- Downstream, the stream feeds the filter's rx_data_R/G/B, pi_flag and i_vs inputs.
- Generates frame framing: a vsync pulse, back porch, H_ACTIVE-pixel lines separated by H_BLANK idle gaps. The gaps let the filter's line buffers drain.

Parameters:
- H_ACTIVE, 640, pixels per line (>=2)
- V_ACTIVE, 480, lines per frame (>=1)
- H_BLANK, 16, idle cycles after the last FIFO read of a line (>=2)
- VS_LEN, 4, cycles o_vs is high at frame start (>=1)
- VBP_LEN, 8, cycles between o_vs falling and the first line (>=1)

Ports:
- sclk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  frame enable; sampled only in IDLE
- fifo_dout  in  16  RGB565 word {R[15:11],G[10:5],B[4:0]}; valid 1 cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  FIFO read strobe
- tx_data_R  out  8  red pixel
- tx_data_G  out  8  green pixel
- tx_data_B  out  8  blue pixel
- po_flag  out  1  pixel valid
- o_vs  out  1  frame sync, high during VSYNC
- frame_done  out  1  1-cycle pulse when the frame completes
- underflow  out  1  sticky: FIFO was empty while pixels were still owed

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Clock port is sclk, reset port is rst.
- Reset values: all outputs 0, state IDLE, all counters 0.
- A reset mid-frame aborts the frame. fifo_rd_en drops in the same cycle the reset is sampled. Any in-flight read is discarded: no po_flag after reset.
- States: IDLE, VSYNC, VBP, LINE, HGAP.
- IDLE -> VSYNC when en=1.
- VSYNC: o_vs=1 for exactly VS_LEN cycles -> VBP.
- VBP: VBP_LEN cycles -> LINE, with line_cnt=0.
- LINE: fifo_rd_en = !fifo_empty && (pix_cnt < H_ACTIVE).
  - pix_cnt increments on each read.
  - After the H_ACTIVE-th read issues, the next state is HGAP.
- HGAP: H_BLANK cycles, then:
  - if line_cnt == V_ACTIVE-1: go to IDLE and pulse frame_done on entry to IDLE;
  - else: line_cnt++, pix_cnt=0, go to LINE.
- fifo_rd_en is 0 in every state other than LINE.
- en is not re-checked mid-frame: deasserting en finishes the current frame first.
- If en=1 in IDLE, the next frame starts the cycle after IDLE: one IDLE cycle minimum between frames.
- Data pipeline latency is 2 cycles:
  - rd_en asserted in cycle t;
  - fifo_dout sampled at the end of t+1;
  - po_flag and data registered out in cycle t+2.
- po_flag is a one-cycle delayed copy of a registered rd_en; there are no other po_flag sources.
- The last pixel of a line appears during HGAP cycle 2. This is why H_BLANK>=2 is required.
- Colour expansion, by bit replication:
  - R = {r5, r5[4:2]}
  - G = {g6, g6[5:4]}
  - B = {b5, b5[4:2]}
- tx_data_R/G/B hold their last value when po_flag=0.
- Underflow rule: in LINE with pix_cnt < H_ACTIVE and fifo_empty=1:
  - stall (no read, pix_cnt holds);
  - set underflow. It clears only on reset.
  - The line stretches; the pixel count per line is never reduced.
- o_vs and po_flag are never high in the same cycle.

Decomposition:
- Shared package pixelbox_stream_pkg holds:
  - state enumeration (IDLE..HGAP);
  - RGB565 field bit positions;
  - function rgb565_to_888, reused by future writer and display blocks.
- Counters and FSM live in this module. No sub-module is required.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VS_LEN=2, VBP_LEN=2):
- Reset held then released, en=0 -> all outputs 0 indefinitely; fifo_rd_en never asserted.
- en=1 with FIFO always non-empty -> o_vs high for exactly 2 cycles, then 2 idle cycles, then 4 consecutive po_flag pulses, a 3-cycle gap, 4 more pulses, and one frame_done pulse. Exactly 8 fifo_rd_en pulses in total.
- fifo_dout=16'hF800, then 16'h07E0, then 16'h001F, then 16'hFFFF -> pixels out 2 cycles after their reads: (FF,00,00), (00,FF,00), (00,00,FF), (FF,FF,FF).
- fifo_empty=1 for 3 cycles after the 2nd pixel read of line 0 -> po_flag gap of 3 cycles; line still carries 4 pixels; underflow=1 and stays 1 through the next frame.
- rst asserted during the 3rd pixel of line 1 -> fifo_rd_en=0 in the same cycle; no po_flag afterwards; no frame_done; restart on en reproduces the full scenario 2 sequence.
- en held high continuously -> frames back-to-back, with frame_done followed by o_vs rise after exactly 1 IDLE cycle.

Source files
------------

// File: rtl/pixelbox_stream_pkg.sv
// Shared definitions for the pixelbox streaming blocks: FSM state encoding,
// RGB565 field layout and the RGB565 -> RGB888 colour expansion.
package pixelbox_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_LINE,
        ST_HGAP
    } stream_state_t;

    // RGB565 word layout {R[15:11], G[10:5], B[4:0]}
    localparam int unsigned RGB565_R_MSB = 15;
    localparam int unsigned RGB565_R_LSB = 11;
    localparam int unsigned RGB565_G_MSB = 10;
    localparam int unsigned RGB565_G_LSB = 5;
    localparam int unsigned RGB565_B_MSB = 4;
    localparam int unsigned RGB565_B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Expand each channel to 8 bits by replicating its top bits into the LSBs,
    // so full-scale inputs map to 8'hFF and zero stays zero.
    function automatic rgb888_t rgb565_to_888(input logic [15:0] word);
        rgb888_t    pix;
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5    = word[RGB565_R_MSB:RGB565_R_LSB];
        g6    = word[RGB565_G_MSB:RGB565_G_LSB];
        b5    = word[RGB565_B_MSB:RGB565_B_LSB];
        pix.r = {r5, r5[4:2]};
        pix.g = {g6, g6[5:4]};
        pix.b = {b5, b5[4:2]};
        return pix;
    endfunction

endpackage

// File: rtl/frame_pixel_streamer.sv
// Frame source for the RGB median-filter chain: pulls RGB565 words from the
// frame-buffer read FIFO and emits framed RGB888 pixels (vsync, back porch,
// active lines separated by idle gaps so downstream line buffers can drain).
module frame_pixel_streamer
    import pixelbox_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned VS_LEN   = 4,
    parameter int unsigned VBP_LEN  = 8
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  tx_data_R,
    output logic [7:0]  tx_data_G,
    output logic [7:0]  tx_data_B,
    output logic        po_flag,
    output logic        o_vs,
    output logic        frame_done,
    output logic        underflow
);

    localparam int unsigned TMAX_A = (VS_LEN > VBP_LEN) ? VS_LEN : VBP_LEN;
    localparam int unsigned TMAX   = (TMAX_A > H_BLANK) ? TMAX_A : H_BLANK;
    localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned PW     = $clog2(H_ACTIVE + 1);
    localparam int unsigned LW     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    stream_state_t   state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]   line_cnt_q, line_cnt_d;
    logic            rd_q, rd_d;
    logic            po_flag_q, po_flag_d;
    rgb888_t         pix_q, pix_d;
    logic            o_vs_q, o_vs_d;
    logic            frame_done_q, frame_done_d;
    logic            underflow_q, underflow_d;

    logic            owed;
    logic            rd_en_c;

    // Read strobe is combinational so it can react to fifo_empty in the same
    // cycle and drop immediately while reset is being sampled.
    always_comb begin
        owed    = (state_q == ST_LINE) && (pix_cnt_q < PW'(H_ACTIVE));
        rd_en_c = owed && !fifo_empty && !rst;
    end

    // Next-state, counter and output-register logic for the framing FSM.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        frame_done_d = 1'b0;
        rd_d         = rd_en_c;
        po_flag_d    = rd_q;
        pix_d        = pix_q;
        underflow_d  = underflow_q | (owed && fifo_empty);

        // Word arrives one cycle after the read; capture it only then.
        if (rd_q) begin
            pix_d = rgb565_to_888(fifo_dout);
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_VSYNC;
                    tmr_d   = '0;
                end
            end
            ST_VSYNC: begin
                if (tmr_q == TW'(VS_LEN - 1)) begin
                    state_d = ST_VBP;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_VBP: begin
                if (tmr_q == TW'(VBP_LEN - 1)) begin
                    state_d    = ST_LINE;
                    tmr_d      = '0;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_LINE: begin
                if (rd_en_c) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == PW'(H_ACTIVE - 1)) begin
                        state_d = ST_HGAP;
                        tmr_d   = '0;
                    end
                end
            end
            ST_HGAP: begin
                if (tmr_q == TW'(H_BLANK - 1)) begin
                    tmr_d = '0;
                    if (line_cnt_q == LW'(V_ACTIVE - 1)) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d    = ST_LINE;
                        line_cnt_d = line_cnt_q + 1'b1;
                        pix_cnt_d  = '0;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase

        o_vs_d = (state_d == ST_VSYNC);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            rd_q         <= 1'b0;
            po_flag_q    <= 1'b0;
            pix_q        <= '0;
            o_vs_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            rd_q         <= rd_d;
            po_flag_q    <= po_flag_d;
            pix_q        <= pix_d;
            o_vs_q       <= o_vs_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign fifo_rd_en = rd_en_c;
    assign tx_data_R  = pix_q.r;
    assign tx_data_G  = pix_q.g;
    assign tx_data_B  = pix_q.b;
    assign po_flag    = po_flag_q;
    assign o_vs       = o_vs_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Self-checking bench for frame_pixel_streamer with a small frame geometry.
// Expected waveforms come from a frame-timeline model built from the framing
// rules (vsync, porch, H reads per line skipping empty cycles, gaps).
module tb_frame_pixel_streamer;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int HB   = 3;
    localparam int VS   = 2;
    localparam int VBP  = 2;
    localparam int MAXN = 400;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  tx_data_R, tx_data_G, tx_data_B;
    logic        po_flag, o_vs, frame_done, underflow;

    frame_pixel_streamer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .H_BLANK  (HB),
        .VS_LEN   (VS),
        .VBP_LEN  (VBP)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .en         (en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx_data_R  (tx_data_R),
        .tx_data_G  (tx_data_G),
        .tx_data_B  (tx_data_B),
        .po_flag    (po_flag),
        .o_vs       (o_vs),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;

    // per-cycle stimulus
    bit          en_v  [MAXN];
    bit          emp_v [MAXN];
    logic [15:0] dout_v[MAXN];
    // per-cycle expectations
    bit          e_rd[MAXN], e_po[MAXN], e_vs[MAXN], e_fd[MAXN], e_uf[MAXN];
    logic [23:0] e_pix[MAXN];
    logic [23:0] e_hold[MAXN];
    // observations
    bit          o_fd_v[MAXN], o_vs_v[MAXN];
    logic [23:0] obs_q[$];
    int          obs_rd, obs_po, obs_fd;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    function automatic logic [23:0] conv(input logic [15:0] w);
        int r5, g6, b5;
        r5 = (w >> 11) & 31;
        g6 = (w >> 5) & 63;
        b5 = w & 31;
        return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            en_v[i]   = 1'b0;
            emp_v[i]  = 1'b0;
            dout_v[i] = 16'($urandom);
        end
    endtask

    // Frame timeline: en seen in idle cycle t0 -> vsync t0+1..t0+VS, porch,
    // each line takes the first H non-empty cycles from its start, then HB
    // gap cycles; pixels show two cycles after their read.
    task automatic build_model(input int n);
        int idle, t0, c, cnt, last, s, uf_from;
        bit incomplete;
        logic [23:0] hold;
        for (int i = 0; i < MAXN; i++) begin
            e_rd[i] = 0; e_po[i] = 0; e_vs[i] = 0; e_fd[i] = 0; e_uf[i] = 0;
            e_pix[i] = '0;
        end
        uf_from = MAXN + 10;
        idle = 0;
        incomplete = 0;
        while (idle < n && !incomplete) begin
            t0 = -1;
            for (int i = idle; i < n; i++) begin
                if (en_v[i]) begin t0 = i; break; end
            end
            if (t0 < 0) break;
            for (int i = 1; i <= VS; i++) if (t0 + i < n) e_vs[t0 + i] = 1;
            s = t0 + 1 + VS + VBP;
            last = s;
            for (int l = 0; l < V && !incomplete; l++) begin
                cnt = 0;
                c = s;
                while (cnt < H && c < n) begin
                    if (!emp_v[c]) begin
                        e_rd[c] = 1;
                        if (c + 2 < n) begin
                            e_po[c + 2]  = 1;
                            e_pix[c + 2] = conv(dout_v[c + 1]);
                        end
                        cnt++;
                        last = c;
                    end else if (uf_from > c + 1) begin
                        uf_from = c + 1;
                    end
                    c++;
                end
                if (cnt < H) incomplete = 1;
                s = last + 1 + HB;
            end
            if (!incomplete) begin
                if (s < n) e_fd[s] = 1;
                idle = s;
            end
        end
        hold = '0;
        for (int i = 0; i < MAXN; i++) begin
            if (e_po[i]) hold = e_pix[i];
            e_hold[i] = hold;
            e_uf[i]   = (i >= uf_from);
        end
    endtask

    // Apply n cycles of stimulus and compare every output each cycle.
    // abort_at >= 0 asserts rst during that cycle; afterwards all outputs
    // are expected at their reset values.
    task automatic run(input int n, input bit do_reset, input int abort_at);
        bit          xr, xp, xv, xf, xu;
        logic [23:0] xd;
        build_model(n);
        obs_q.delete();
        obs_rd = 0; obs_po = 0; obs_fd = 0;
        if (do_reset) begin
            rst = 1'b1; en = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
            repeat (3) @(posedge sclk);
            #1;
            chk("rst_rd", -1, 32'(fifo_rd_en), 0);
            chk("rst_po", -1, 32'(po_flag), 0);
            chk("rst_vs", -1, 32'(o_vs), 0);
            chk("rst_fd", -1, 32'(frame_done), 0);
            chk("rst_uf", -1, 32'(underflow), 0);
            chk("rst_rgb", -1, 32'({tx_data_R, tx_data_G, tx_data_B}), 0);
            rst = 1'b0;
        end
        for (int c = 0; c < n; c++) begin
            en = en_v[c]; fifo_empty = emp_v[c]; fifo_dout = dout_v[c];
            rst = (c == abort_at);
            @(negedge sclk);
            xr = e_rd[c]; xp = e_po[c]; xv = e_vs[c]; xf = e_fd[c]; xu = e_uf[c]; xd = e_hold[c];
            if (abort_at >= 0 && c == abort_at) xr = 0;
            if (abort_at >= 0 && c > abort_at) begin
                xr = 0; xp = 0; xv = 0; xf = 0; xu = 0; xd = '0;
            end
            chk("fifo_rd_en", c, 32'(fifo_rd_en), 32'(xr));
            chk("po_flag", c, 32'(po_flag), 32'(xp));
            chk("o_vs", c, 32'(o_vs), 32'(xv));
            chk("frame_done", c, 32'(frame_done), 32'(xf));
            chk("underflow", c, 32'(underflow), 32'(xu));
            chk("tx_R", c, 32'(tx_data_R), 32'(xd[23:16]));
            chk("tx_G", c, 32'(tx_data_G), 32'(xd[15:8]));
            chk("tx_B", c, 32'(tx_data_B), 32'(xd[7:0]));
            o_fd_v[c] = frame_done;
            o_vs_v[c] = o_vs;
            if (fifo_rd_en) obs_rd++;
            if (frame_done) obs_fd++;
            if (po_flag) begin
                obs_po++;
                obs_q.push_back({tx_data_R, tx_data_G, tx_data_B});
            end
            @(posedge sclk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic setup_table_frame(input int n);
        int k;
        clear_stim();
        en_v[0] = 1'b1;
        build_model(n);
        k = 0;
        for (int c = 0; c < n; c++) begin
            if (e_rd[c] && k < 8) begin
                dout_v[c + 1] = tbl[k].word;
                k++;
            end
        end
    endtask

    initial begin
        int fd_c;
        logic [23:0] got;
        tbl[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
        tbl[1] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
        tbl[2] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
        tbl[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[4] = '{16'h0000, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{16'h8410, 8'h84, 8'h82, 8'h84};
        tbl[6] = '{16'h1234, 8'h10, 8'h45, 8'hA5};
        tbl[7] = '{16'h7BEF, 8'h7B, 8'h7D, 8'h7B};

        // en low: nothing ever happens, whatever the FIFO does
        clear_stim();
        for (int i = 0; i < MAXN; i++) emp_v[i] = ($urandom_range(1) == 1);
        run(30, 1, -1);
        chk("idle_rd_count", 0, 32'(obs_rd), 0);

        // one full frame, FIFO never empty, table-driven colour checks
        setup_table_frame(40);
        run(40, 1, -1);
        chk("rd_count", 0, 32'(obs_rd), 8);
        chk("po_count", 0, 32'(obs_po), 8);
        chk("fd_count", 0, 32'(obs_fd), 1);
        for (int k = 0; k < 8; k++) begin
            got = (k < obs_q.size()) ? obs_q[k] : 24'hXXXXXX;
            chk("tbl_pixel", k, 32'(got), 32'({tbl[k].r, tbl[k].g, tbl[k].b}));
        end

        // underflow: FIFO empty 3 cycles after 2nd read of line 0, then a
        // second frame started while en is held; underflow must stay set
        clear_stim();
        en_v[0] = 1'b1;
        for (int i = 7; i <= 9; i++) emp_v[i] = 1'b1;
        for (int i = 20; i <= 30; i++) en_v[i] = 1'b1;
        run(70, 1, -1);
        chk("uf_po_count", 0, 32'(obs_po), 16);
        chk("uf_sticky", 0, 32'(underflow), 1);

        // reset during the 3rd read of line 1 aborts the frame, then a
        // restart without a further reset reproduces the full frame
        setup_table_frame(40);
        run(40, 1, 14);
        chk("abort_fd_count", 0, 32'(obs_fd), 0);
        setup_table_frame(40);
        run(40, 0, -1);
        chk("restart_rd_count", 0, 32'(obs_rd), 8);
        chk("restart_po_count", 0, 32'(obs_po), 8);
        for (int k = 0; k < 8; k++) begin
            got = (k < obs_q.size()) ? obs_q[k] : 24'hXXXXXX;
            chk("restart_pixel", k, 32'(got), 32'({tbl[k].r, tbl[k].g, tbl[k].b}));
        end

        // en held high: back-to-back frames, one idle cycle between them
        clear_stim();
        for (int i = 0; i < MAXN; i++) en_v[i] = 1'b1;
        run(70, 1, -1);
        fd_c = -1;
        for (int c = 0; c < 69; c++) begin
            if (o_fd_v[c] && fd_c < 0) fd_c = c;
        end
        chk("b2b_fd_seen", 0, 32'(fd_c >= 0), 1);
        if (fd_c >= 0) begin
            chk("b2b_vs_next", fd_c, 32'(o_vs_v[fd_c + 1]), 1);
            chk("b2b_vs_same", fd_c, 32'(o_vs_v[fd_c]), 0);
        end

        // randomized FIFO occupancy, data and enable pulses
        for (int it = 0; it < 3; it++) begin
            clear_stim();
            for (int i = 0; i < MAXN; i++) begin
                emp_v[i] = ($urandom_range(99) < 30);
                en_v[i]  = ($urandom_range(99) < 10);
            end
            run(300, 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
